// File: rtl/dram_bus_pkg.sv
// Shared definitions for the DRAM line manager: FSM encoding, burst
// geometry, the atomic-op code driven on awatop and the default bus ID.
package dram_bus_pkg;

    localparam int BEATS  = 4;
    localparam int BEAT_W = 32;
    localparam int LINE_W = BEAT_W * BEATS;

    // Beat counter value of the final beat in a burst.
    localparam logic [1:0] LAST_CNT = 2'(BEATS - 1);

    // Plain (non-atomic) write.
    localparam logic [5:0] ATOP_NONE = 6'd0;

    // ID placed on awid/arid and expected back on bid/rid.
    localparam logic [3:0] MID_DEFAULT = 4'h1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_RSP  = 3'd6
    } state_t;

endpackage

// File: rtl/dram_line_beat_mux.sv
// Selects one 32-bit beat out of a 128-bit cache line; beat n occupies
// bits [32n+31:32n].
module dram_line_beat_mux
    import dram_bus_pkg::*;
(
    input  logic [LINE_W-1:0] line,
    input  logic [1:0]        sel,
    output logic [BEAT_W-1:0] beat
);

    // Pure select of the addressed beat.
    always_comb begin
        beat = line[31:0];
        case (sel)
            2'd0: beat = line[31:0];
            2'd1: beat = line[63:32];
            2'd2: beat = line[95:64];
            2'd3: beat = line[127:96];
            default: beat = line[31:0];
        endcase
    end

endmodule

// File: rtl/dram_line_mngr.sv
// Cache-line bus initiator: turns one 128-bit line request into a 4-beat
// 32-bit burst (AW/W/B for writes, AR/R for reads) and reports completion
// with a one-cycle rsp_valid pulse. One request outstanding at a time.
// Optional macro BUS_TIMEOUT_EN adds a wait-cycle limit in the B and R
// states; when it expires the request completes with rsp_err=1.
module dram_line_mngr
    import dram_bus_pkg::*;
#(
    parameter logic [3:0] MID         = MID_DEFAULT,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        awid,
    output logic [31:0]       awaddr,
    output logic [5:0]        awatop,
    output logic              wvalid,
    input  logic              wready,
    output logic [BEAT_W-1:0] wdata,
    output logic              wlast,
    input  logic              bvalid,
    output logic              bready,
    input  logic [3:0]        bid,
    input  logic              bcomp,
    output logic              arvalid,
    input  logic              arready,
    output logic [3:0]        arid,
    output logic [31:0]       araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [3:0]        rid,
    input  logic [BEAT_W-1:0] rdata,
    input  logic              rlast
);

    state_t            state, state_nxt;
    logic [31:0]       addr_q;
    logic [1:0]        cnt;
    logic              err;
    logic [LINE_W-1:0] wline;
    logic [LINE_W-1:0] rline;
    logic [LINE_W-1:0] line_upd;
    logic              timeout_hit;

    // Outgoing write beat chosen by the beat counter.
    dram_line_beat_mux u_beat_mux (
        .line (wline),
        .sel  (cnt),
        .beat (wdata)
    );

`ifdef BUS_TIMEOUT_EN
    localparam logic [10:0] WAIT_LAST = 11'(TIMEOUT_CYC - 1);

    logic [10:0] wait_cnt;
    logic        in_wait;
    logic        wait_hs;

    assign in_wait = (state == ST_B) || (state == ST_R);
    assign wait_hs = ((state == ST_B) && bvalid) || ((state == ST_R) && rvalid);

    // The increment that would reach TIMEOUT_CYC ends the wait instead.
    assign timeout_hit = in_wait && !wait_hs && (wait_cnt == WAIT_LAST);

    // Count idle cycles spent waiting for B or R; any handshake restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!in_wait || wait_hs) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 11'd1;
        end
    end
`else
    // Without the timeout option B and R wait indefinitely.
    assign timeout_hit = 1'b0;
`endif

    // Read line with the incoming beat merged into its slot.
    always_comb begin
        line_upd = rline;
        case (cnt)
            2'd0: line_upd[31:0]   = rdata;
            2'd1: line_upd[63:32]  = rdata;
            2'd2: line_upd[95:64]  = rdata;
            2'd3: line_upd[127:96] = rdata;
            default: line_upd = rline;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and bus/response strobes.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = req_we ? ST_AW : ST_AR;
                end
            end
            ST_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_nxt = ST_W;
                end
            end
            ST_W: begin
                wvalid = 1'b1;
                wlast  = (cnt == LAST_CNT);
                if (wready && (cnt == LAST_CNT)) begin
                    state_nxt = ST_B;
                end
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid || timeout_hit) begin
                    state_nxt = ST_RSP;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_nxt = ST_R;
                end
            end
            ST_R: begin
                rready = 1'b1;
                // Completion is decided by beat count, not by rlast.
                if ((rvalid && (cnt == LAST_CNT)) || timeout_hit) begin
                    state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request address, beat counter, error flag and completed read line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q   <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            rsp_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr & ~32'hF;
                        cnt    <= '0;
                        err    <= 1'b0;
                    end
                end
                ST_W: begin
                    if (wready) begin
                        cnt <= cnt + 2'd1;
                    end
                end
                ST_B: begin
                    if (bvalid) begin
                        err <= err | (bid != MID) | ~bcomp;
                    end else if (timeout_hit) begin
                        err <= 1'b1;
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        cnt <= '0;
                    end
                end
                ST_R: begin
                    if (rvalid) begin
                        cnt <= cnt + 2'd1;
                        err <= err | (rid != MID) | (rlast != (cnt == LAST_CNT));
                        if (cnt == LAST_CNT) begin
                            rsp_data <= line_upd;
                        end
                    end else if (timeout_hit) begin
                        // Abandoned read returns whatever beats arrived.
                        err      <= 1'b1;
                        rsp_data <= rline;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line buffers; contents only matter once a request has been accepted.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && req_valid) begin
            wline <= req_wdata;
            rline <= '0;
        end else if ((state == ST_R) && rvalid) begin
            rline <= line_upd;
        end
    end

    assign rsp_err = err;
    assign awid    = MID;
    assign arid    = MID;
    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign awatop  = ATOP_NONE;

endmodule
